// File: rtl/aes_inv_key_sched_if.sv
// Round-key stream bundle for aes_inv_key_sched: start/last_key in, valid/ready round keys out.
// master drives start/last_key/rk_ready; slave (the key scheduler) drives the rest.
interface aes_inv_key_sched_if;
  logic         start;
  logic [127:0] last_key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         done;

  modport master (
    output start, last_key, rk_ready,
    input  busy, rk_valid, rk_out, rk_round, done
  );

  modport slave (
    input  start, last_key, rk_ready,
    output busy, rk_valid, rk_out, rk_round, done
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key schedule: walks round key 10 back to round key 0.
// Build macro INV_KEYSCHED_STREAM_EN: emit all 11 keys; undefined: emit only round-0 key.
module aes_inv_key_sched (
  input  logic              clk,
  input  logic              rst,
  aes_inv_key_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STEP, EMIT, DONE} state_t;

  // Forward AES S-box, byte 0x00 in the top bits.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Undo one expansion round: key r -> key r-1, using Rcon of round r.
  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon(r), 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  state_t         state, state_nxt;
  logic [127:0]   key_reg, key_nxt, key_step;
  logic [3:0]     round_reg, round_nxt;

  assign key_step     = inv_step(key_reg, round_reg);
  assign bus.rk_out   = key_reg;
  assign bus.rk_round = round_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_reg   <= '0;
      round_reg <= '0;
    end else begin
      state     <= state_nxt;
      key_reg   <= key_nxt;
      round_reg <= round_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = key_reg;
    round_nxt = round_reg;
    case (state)
      IDLE: begin
        if (bus.start) begin
          key_nxt   = bus.last_key;
          round_nxt = 4'd10;
`ifdef INV_KEYSCHED_STREAM_EN
          state_nxt = EMIT;
`else
          state_nxt = STEP;
`endif
        end
      end
`ifndef INV_KEYSCHED_STREAM_EN
      STEP: begin
        key_nxt   = key_step;
        round_nxt = round_reg - 4'd1;
        if (round_reg == 4'd1) state_nxt = EMIT;
      end
`endif
      EMIT: begin
        if (bus.rk_ready) begin
          if (round_reg != 4'd0) begin
            key_nxt   = key_step;
            round_nxt = round_reg - 4'd1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = 1'b0;
    bus.rk_valid = 1'b0;
    bus.done     = 1'b0;
    case (state)
      STEP: bus.busy = 1'b1;
      EMIT: begin
        bus.busy     = 1'b1;
        bus.rk_valid = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: forward key-expansion model feeds a scoreboard of expected round keys.
// Handles both builds (INV_KEYSCHED_STREAM_EN defined or not).
module tb_aes_inv_key_sched;

  logic clk = 1'b0;
  logic rst;
  aes_inv_key_sched_if bus ();

  aes_inv_key_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  logic [7:0]   sb [256];
  logic [7:0]   rc [1:10];
  logic [127:0] fwd_rk [0:10];
  logic [127:0] got_key [0:10];
  logic [127:0] exp_key [$];
  logic [3:0]   exp_rnd [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from GF(2^8) inverse plus affine map; Rcon by repeated doubling.
  task automatic build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    rc[1] = 8'h01;
    for (int j = 2; j <= 10; j++) rc[j] = gmul(rc[j-1], 8'h02);
  endtask

  task automatic expand(input logic [127:0] ck);
    logic [31:0] w [0:43];
    logic [31:0] t;
    {w[0], w[1], w[2], w[3]} = ck;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) fwd_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // mode 0: rk_ready high; 1: rk_ready 1,0,0 repeating; 2: rk_ready high plus a stray start mid-run.
  task automatic run_vec(input logic [127:0] ck, input int mode, input string tag);
    logic [127:0] hold_k, ek;
    logic [3:0]   hold_r, er;
    bit           stalled, fin;
    int           lo;
    stalled = 1'b0;
    fin     = 1'b0;
    expand(ck);
    for (int r = 0; r <= 10; r++) got_key[r] = '0;
`ifdef INV_KEYSCHED_STREAM_EN
    lo = 10;
`else
    lo = 0;
`endif
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.last_key = fwd_rk[10];
    bus.rk_ready = 1'b1;
    for (int r = lo; r >= 0; r--) begin
      exp_key.push_back(fwd_rk[r]);
      exp_rnd.push_back(4'(r));
    end
    for (int c = 1; c <= 80 && !fin; c++) begin
      @(posedge clk); #1;
      bus.start    = (mode == 2 && c == 3);
      bus.last_key = (mode == 2) ? ~fwd_rk[10] : fwd_rk[10];
      bus.rk_ready = (mode == 1) ? ((c - 1) % 3 == 0) : 1'b1;
      @(negedge clk);
      if (c == 1) chk({tag, " busy@T+1"}, 128'(bus.busy), 128'(1));
`ifdef INV_KEYSCHED_STREAM_EN
      if (c == 1) chk({tag, " valid@T+1"}, 128'(bus.rk_valid), 128'(1));
`else
      if (c <= 10) chk({tag, " no valid in STEP"}, 128'(bus.rk_valid), 128'(0));
`endif
      if (stalled) begin
        chk({tag, " held key"}, bus.rk_out, hold_k);
        chk({tag, " held round"}, 128'(bus.rk_round), 128'(hold_r));
      end
      stalled = bus.rk_valid && !bus.rk_ready;
      hold_k  = bus.rk_out;
      hold_r  = bus.rk_round;
      if (bus.rk_valid && bus.rk_ready) begin
        chk({tag, " key pending"}, 128'(exp_key.size() != 0), 128'(1));
        if (exp_key.size() != 0) begin
          ek = exp_key.pop_front();
          er = exp_rnd.pop_front();
          chk({tag, " rk_out"}, bus.rk_out, ek);
          chk({tag, " rk_round"}, 128'(bus.rk_round), 128'(er));
          got_key[er] = bus.rk_out;
          if (mode != 1) chk({tag, " xfer cycle"}, 128'(c), 128'(11 - int'(er)));
        end
      end
      if (bus.done) begin
        chk({tag, " all keys out"}, 128'(exp_key.size()), 128'(0));
        chk({tag, " busy low at done"}, 128'(bus.busy), 128'(0));
        if (mode != 1) chk({tag, " done cycle"}, 128'(c), 128'(12));
        fin = 1'b1;
      end
    end
    chk({tag, " done seen"}, 128'(fin), 128'(1));
    exp_key.delete();
    exp_rnd.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " done one cycle"}, 128'(bus.done), 128'(0));
    chk({tag, " idle after"}, 128'(bus.busy), 128'(0));
  endtask

  task automatic abort_run(input logic [127:0] ck);
    expand(ck);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.last_key = fwd_rk[10];
    bus.rk_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
`ifdef INV_KEYSCHED_STREAM_EN
    chk("abort round5 shown", 128'(bus.rk_round), 128'(5));
`else
    chk("abort busy in STEP", 128'(bus.busy), 128'(1));
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy", 128'(bus.busy), 128'(0));
    chk("abort rk_valid", 128'(bus.rk_valid), 128'(0));
    chk("abort done", 128'(bus.done), 128'(0));
    chk("abort rk_out", bus.rk_out, 128'h0);
    chk("abort rk_round", 128'(bus.rk_round), 128'(0));
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort quiet", 128'({bus.rk_valid, bus.done}), 128'(0));
    end
  endtask

  initial begin
    logic [127:0] rk;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.last_key = '0;
    bus.rk_ready = 1'b0;
    build_tables();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset busy", 128'(bus.busy), 128'(0));
    chk("reset rk_valid", 128'(bus.rk_valid), 128'(0));
    chk("reset done", 128'(bus.done), 128'(0));
    chk("reset rk_out", bus.rk_out, 128'h0);
    chk("reset rk_round", 128'(bus.rk_round), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    run_vec(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, "fips");
    chk("fips round0", got_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
`ifdef INV_KEYSCHED_STREAM_EN
    chk("fips round10", got_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips round9", got_key[9], 128'hac7766f319fadc2128d12941575c006e);
`endif
    run_vec(128'h2b7e151628aed2a6abf7158809cf4f3c, 1, "stall");
    run_vec(128'h2b7e151628aed2a6abf7158809cf4f3c, 2, "restart");
    abort_run(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_vec(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, "after_rst");
    chk("after_rst round0", got_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_vec(128'h000102030405060708090a0b0c0d0e0f, 0, "appc");
    chk("appc round0", got_key[0], 128'h000102030405060708090a0b0c0d0e0f);
    rk = {$urandom, $urandom, $urandom, $urandom};
    run_vec(rk, 1, "rand");
    chk("rand round0", got_key[0], rk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

- Iterative AES-128 inverse key schedule: runs the key expansion backwards.
- Takes the last round key (round 10, words w[40..43]) and regenerates round keys 10 down to 0, one per cycle over a valid/ready stream.
- Feeds the decryption datapath, which consumes round keys in reverse order.
- Lets the design store only the final round key instead of the full 1408-bit expanded schedule.

## Interface
Parameters: none.
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- start  input  1  begin a run; sampled only in IDLE
- last_key  input  128  round-10 key, w[40] in [127:96] … w[43] in [31:0]; sampled on accepted start
- busy  output  1  high from the cycle after accepted start until the run completes
- rk_valid  output  1  rk_out/rk_round hold a valid round key
- rk_ready  input  1  downstream accepts; a transfer occurs when rk_valid && rk_ready
- rk_out  output  128  round key; w[4r] in [127:96] … w[4r+3] in [31:0]
- rk_round  output  4  round index r of rk_out (10..0)
- done  output  1  one-cycle pulse after the round-0 key is transferred

## Operation
- Reverse step from round r to r-1 (r = 10..1), words from the current key:
  - p3 = w[4r+3]^w[4r+2]
  - p2 = w[4r+2]^w[4r+1]
  - p1 = w[4r+1]^w[4r]
  - p0 = w[4r] ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- RotWord: [a0,a1,a2,a3] → [a1,a2,a3,a0].
- SubWord: standard AES forward S-box applied to each byte; four instances, implemented locally.
- All XORs are 32-bit, with no carries or width growth.
- FSM states: IDLE, STEP, EMIT, DONE.
  - IDLE: on start, latch last_key into key_reg and set round_reg=10, then go to EMIT. With INV_KEYSCHED_STREAM_EN undefined, go to STEP instead.
  - STEP (non-stream build only): each cycle key_reg ← reverse step and round_reg−1. When round_reg reaches 0, go to EMIT.
  - EMIT: rk_valid=1.
    - On a transfer with round_reg>0, key_reg ← reverse step and round_reg−1; stay in EMIT.
    - On a transfer with round_reg==0, go to DONE.
    - Without a transfer, hold key_reg and round_reg.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- rk_out = key_reg and rk_round = round_reg at all times. Both are stable while rk_valid && !rk_ready.
- start outside IDLE is ignored. last_key is don't-care except on an accepted start.

## Timing
- Reset values (rst high at a clock edge): state=IDLE; busy, rk_valid, done = 0; rk_out = 128'h0; rk_round = 4'h0.
- Reset mid-run aborts immediately. No done pulse and no further rk_valid.
- Stream build, start accepted at cycle T:
  - busy=1 and rk_valid=1 with round 10 at T+1.
  - With rk_ready held high, rounds 10..0 appear at T+1..T+11, one transfer per cycle.
  - done=1 at T+12 and busy=0 at T+12.
  - Each low cycle of rk_ready adds one cycle to the run.
- Non-stream build, start at T:
  - busy=1 at T+1.
  - STEP covers T+1..T+10.
  - rk_valid=1 with round 0 from T+11 until transfer.
  - done is asserted the cycle after the transfer.
- A new start is accepted in the IDLE cycle after DONE, at T+13 at the earliest in the stream build.
- rk_ready is ignored while rk_valid=0.

## Configuration
- INV_KEYSCHED_STREAM_EN defined: all 11 round keys (10..0) are presented through the handshake. This is the decryption-datapath build.
- INV_KEYSCHED_STREAM_EN undefined:
  - STEP state is compiled in.
  - Rounds are computed internally without handshakes.
  - Only the round-0 key (the recovered cipher key) is presented once, with rk_round=0.

## Test plan
- FIPS-197 vector, stream build, rk_ready=1, last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, start at T → round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at T+1; round 9 = ac7766f319fadc2128d12941575c006e at T+2; round 0 = 2b7e151628aed2a6abf7158809cf4f3c at T+11; done pulse at T+12.
- Same vector, rk_ready toggling 1,0,0,1,… → rk_out/rk_round held while stalled; the 11 keys match the forward KeyGen outputs in reverse order; no key is duplicated or dropped.
- start re-asserted while busy with a different last_key → ignored; output sequence unchanged.
- rst pulsed during round 5 → next cycle all outputs zero and IDLE; a subsequent start reproduces the full sequence correctly.
- Non-stream build, same vector → rk_valid first high at T+11 with rk_round=0 and rk_out=2b7e151628aed2a6abf7158809cf4f3c; exactly one transfer; done the following cycle.
- last_key = forward KeyGen round 10 of key 000102030405060708090a0b0c0d0e0f → round 0 output = 000102030405060708090a0b0c0d0e0f.
